// File: rtl/onehot_seq_pkg.sv
// Shared encodings for the one-hot sequencing decoder: command modes and FSM states.
package onehot_seq_pkg;

   localparam logic [1:0] MODE_DECODE = 2'b00;
   localparam logic [1:0] MODE_BCAST  = 2'b01;
   localparam logic [1:0] MODE_SCAN   = 2'b10;
   localparam logic [1:0] MODE_RSVD   = 2'b11;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BEAT = 1'b1;

endpackage

// File: rtl/onehot_seq_decoder_dec.sv
// Combinational index-to-one-hot decoder; an index at or beyond NUM_OUT decodes to all zeros.
module onehot_dec #(
   parameter int CODE_W  = 5,
   parameter int NUM_OUT = 32
) (
   input  logic [CODE_W-1:0]  index_i,
   output logic [NUM_OUT-1:0] onehot_o
);

   always_comb begin
      onehot_o = '0;
      for (int i = 0; i < NUM_OUT; i++) begin
         if (index_i == CODE_W'(i)) onehot_o[i] = 1'b1;
      end
   end

endmodule

// File: rtl/onehot_seq_decoder.sv
// Registered one-hot lane-enable sequencer: single decode, broadcast and wrap-around scan,
// driven by a command stream and emitting beats on a registered output stream.
module onehot_seq_decoder
   import onehot_seq_pkg::*;
#(
   parameter int CODE_W  = 5,
   parameter int NUM_OUT = 32,
   parameter int LEN_W   = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [1:0]         cmd_mode,
   input  logic [CODE_W-1:0]  cmd_code,
   input  logic [LEN_W-1:0]   cmd_len,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [NUM_OUT-1:0] out_onehot,
   output logic [CODE_W-1:0]  out_index,
   output logic               out_last,
   output logic               err_pulse
);

   localparam logic [CODE_W:0]   NUM_OUT_C = (CODE_W+1)'(NUM_OUT);
   localparam logic [CODE_W-1:0] LAST_IDX  = CODE_W'(NUM_OUT - 1);

   logic [0:0]         state_q,  state_d;
   logic [CODE_W-1:0]  index_q,  index_d;
   logic [NUM_OUT-1:0] onehot_q, onehot_d;
   logic               last_q,   last_d;
   logic               err_q,    err_d;
   logic [LEN_W-1:0]   remain_q, remain_d;

   logic               beat_acc;
   logic               cmd_acc;
   logic               cmd_bad;
   logic               sel_bcast;
   logic [CODE_W-1:0]  next_idx;
   logic [NUM_OUT-1:0] dec_onehot;

   // Both streams transfer on a clock edge where valid & ready are high; a producer keeps its
   // payload stable while valid is high and ready is low, and never withdraws valid before transfer.
   assign out_valid  = (state_q == ST_BEAT);
   assign out_onehot = onehot_q;
   assign out_index  = index_q;
   assign out_last   = last_q;
   assign err_pulse  = err_q;

   assign beat_acc  = out_valid & out_ready;
   assign cmd_ready = !out_valid | (beat_acc & last_q);
   assign cmd_acc   = cmd_valid & cmd_ready;
   assign cmd_bad   = (cmd_mode == MODE_RSVD) ||
                      ((cmd_mode != MODE_BCAST) && ({1'b0, cmd_code} >= NUM_OUT_C));

   // Index the output register will hold after this edge; wraps at NUM_OUT, not 2**CODE_W.
   always_comb begin
      next_idx  = index_q;
      sel_bcast = 1'b0;
      if (cmd_acc) begin
         if (cmd_mode == MODE_BCAST) begin
            next_idx  = '0;
            sel_bcast = 1'b1;
         end else begin
            next_idx = cmd_code;
         end
      end else if (beat_acc && !last_q) begin
         next_idx = (index_q == LAST_IDX) ? '0 : index_q + CODE_W'(1);
      end
   end

   onehot_dec #(
      .CODE_W  (CODE_W),
      .NUM_OUT (NUM_OUT)
   ) u_dec (
      .index_i  (next_idx),
      .onehot_o (dec_onehot)
   );

   always_comb begin
      state_d  = state_q;
      index_d  = index_q;
      onehot_d = onehot_q;
      last_d   = last_q;
      remain_d = remain_q;
      err_d    = 1'b0;
      if (cmd_acc) begin
         if (cmd_bad) begin
            state_d  = ST_IDLE;
            index_d  = '0;
            onehot_d = '0;
            last_d   = 1'b0;
            remain_d = '0;
            err_d    = 1'b1;
         end else begin
            state_d  = ST_BEAT;
            index_d  = next_idx;
            onehot_d = sel_bcast ? '1 : dec_onehot;
            if (cmd_mode == MODE_SCAN) begin
               remain_d = cmd_len;
               last_d   = (cmd_len == '0);
            end else begin
               remain_d = '0;
               last_d   = 1'b1;
            end
         end
      end else if (beat_acc) begin
         if (last_q) begin
            state_d  = ST_IDLE;
            index_d  = '0;
            onehot_d = '0;
            last_d   = 1'b0;
            remain_d = '0;
         end else begin
            index_d  = next_idx;
            onehot_d = dec_onehot;
            remain_d = remain_q - LEN_W'(1);
            last_d   = (remain_q == LEN_W'(1));
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         index_q  <= '0;
         onehot_q <= '0;
         last_q   <= 1'b0;
         err_q    <= 1'b0;
         remain_q <= '0;
      end else begin
         state_q  <= state_d;
         index_q  <= index_d;
         onehot_q <= onehot_d;
         last_q   <= last_d;
         err_q    <= err_d;
         remain_q <= remain_d;
      end
   end

endmodule

// File: tb/tb_onehot_seq_decoder.sv
// Bench for onehot_seq_decoder: a 32-lane and a 20-lane instance share one stimulus port,
// a negedge monitor scoreboards beats and error pulses, scenario tasks add targeted checks.
module tb_onehot_seq_decoder;

   localparam int W = 38;  // {last, index[4:0], onehot[31:0]}

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        sel = 1'b0;   // 0: NUM_OUT=32 instance, 1: NUM_OUT=20 instance
   logic        cmd_valid = 1'b0;
   logic [1:0]  cmd_mode = 2'b00;
   logic [4:0]  cmd_code = 5'd0;
   logic [4:0]  cmd_len = 5'd0;
   logic        out_ready = 1'b1;
   logic        rand_ready = 1'b0;

   logic        cmd_ready_a, out_valid_a, out_last_a, err_a;
   logic [31:0] onehot_a;
   logic [4:0]  index_a;
   logic        cmd_ready_b, out_valid_b, out_last_b, err_b;
   logic [19:0] onehot_b;
   logic [4:0]  index_b;

   logic        cmd_ready, out_valid, out_last, err_pulse;
   logic [31:0] out_onehot;
   logic [4:0]  out_index;

   logic [W-1:0] exp_q[$];
   logic         err_due = 1'b0;
   int           idle_cycles = 0;
   int           checks = 0;
   int           errors = 0;
   int           num;
   int           idx;
   logic [31:0]  one_v;
   logic [31:0]  all_v;

   onehot_seq_decoder #(.CODE_W(5), .NUM_OUT(32), .LEN_W(5)) u_dut32 (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid & ~sel),
      .cmd_ready  (cmd_ready_a),
      .cmd_mode   (cmd_mode),
      .cmd_code   (cmd_code),
      .cmd_len    (cmd_len),
      .out_valid  (out_valid_a),
      .out_ready  (out_ready),
      .out_onehot (onehot_a),
      .out_index  (index_a),
      .out_last   (out_last_a),
      .err_pulse  (err_a)
   );

   onehot_seq_decoder #(.CODE_W(5), .NUM_OUT(20), .LEN_W(5)) u_dut20 (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid & sel),
      .cmd_ready  (cmd_ready_b),
      .cmd_mode   (cmd_mode),
      .cmd_code   (cmd_code),
      .cmd_len    (cmd_len),
      .out_valid  (out_valid_b),
      .out_ready  (out_ready),
      .out_onehot (onehot_b),
      .out_index  (index_b),
      .out_last   (out_last_b),
      .err_pulse  (err_b)
   );

   assign cmd_ready  = sel ? cmd_ready_b : cmd_ready_a;
   assign out_valid  = sel ? out_valid_b : out_valid_a;
   assign out_last   = sel ? out_last_b  : out_last_a;
   assign err_pulse  = sel ? err_b       : err_a;
   assign out_index  = sel ? index_b     : index_a;
   assign out_onehot = sel ? {12'd0, onehot_b} : onehot_a;

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   always @(posedge clk) begin
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
   end

   // scoreboard monitor: compares held/accepted beats and error pulses, then models new commands
   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_beat: got last=%0b index=%0d onehot=%h, required no beat",
                        out_last, out_index, out_onehot);
            end else begin
               if ({out_last, out_index, out_onehot} !== exp_q[0]) begin
                  errors++;
                  $display("FAIL beat: got last=%0b index=%0d onehot=%h, required last=%0b index=%0d onehot=%h",
                           out_last, out_index, out_onehot, exp_q[0][37], exp_q[0][36:32], exp_q[0][31:0]);
               end
               if (out_ready) void'(exp_q.pop_front());
            end
         end else begin
            idle_cycles++;
         end
         if (err_due || err_pulse) begin
            checks++;
            if (err_pulse !== err_due) begin
               errors++;
               $display("FAIL err_pulse: got %0b, required %0b", err_pulse, err_due);
            end
         end
         err_due = 1'b0;
         if (cmd_valid && cmd_ready) begin
            num   = sel ? 20 : 32;
            all_v = sel ? 32'h000F_FFFF : 32'hFFFF_FFFF;
            one_v = 32'd1;
            if (cmd_mode == 2'b11 || (cmd_mode != 2'b01 && int'(cmd_code) >= num)) begin
               err_due = 1'b1;
            end else if (cmd_mode == 2'b00) begin
               exp_q.push_back({1'b1, cmd_code, one_v << cmd_code});
            end else if (cmd_mode == 2'b01) begin
               exp_q.push_back({1'b1, 5'd0, all_v});
            end else begin
               for (int k = 0; k <= int'(cmd_len); k++) begin
                  idx = (int'(cmd_code) + k) % num;
                  exp_q.push_back({k == int'(cmd_len), 5'(idx), one_v << idx});
               end
            end
         end
      end
   end

   // driver tasks
   task automatic issue(input logic [1:0] m, input logic [4:0] c, input logic [4:0] l);
      bit ok = 1'b0;
      cmd_mode  = m;
      cmd_code  = c;
      cmd_len   = l;
      cmd_valid = 1'b1;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (cmd_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL cmd_timeout: got cmd_ready=0 for 200 cycles, required acceptance");
      end
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic drain();
      bit done = 1'b0;
      for (int n = 0; n < 300; n++) begin
         @(posedge clk);
         #2;
         if (exp_q.size() == 0 && !out_valid) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d beats pending, required 0", exp_q.size());
      end
   endtask

   // scenarios
   task automatic test_reset();
      #2 rst = 1'b1;
      #1;
      checks += 6;
      if (out_valid !== 1'b0)   begin errors++; $display("FAIL rst_out_valid: got %0b, required 0", out_valid); end
      if (out_onehot !== 32'd0) begin errors++; $display("FAIL rst_onehot: got %h, required 0", out_onehot); end
      if (out_index !== 5'd0)   begin errors++; $display("FAIL rst_index: got %0d, required 0", out_index); end
      if (out_last !== 1'b0)    begin errors++; $display("FAIL rst_last: got %0b, required 0", out_last); end
      if (err_pulse !== 1'b0)   begin errors++; $display("FAIL rst_err: got %0b, required 0", err_pulse); end
      if (cmd_ready !== 1'b1)   begin errors++; $display("FAIL rst_cmd_ready: got %0b, required 1", cmd_ready); end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_decode();
      issue(2'b00, 5'd0, 5'd0);
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL decode0_latency: got out_valid=%0b, required 1", out_valid); end
      drain();
      issue(2'b00, 5'd31, 5'd0);
      checks++;
      if (out_onehot !== 32'h8000_0000) begin errors++; $display("FAIL decode31_onehot: got %h, required 80000000", out_onehot); end
      drain();
   endtask

   task automatic test_bcast_hold();
      out_ready = 1'b0;
      issue(2'b01, 5'd3, 5'd0);
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         checks += 2;
         if (out_onehot !== 32'hFFFF_FFFF) begin errors++; $display("FAIL bcast_hold_onehot: got %h, required ffffffff", out_onehot); end
         if (cmd_ready !== 1'b0) begin errors++; $display("FAIL bcast_hold_cmd_ready: got %0b, required 0", cmd_ready); end
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      #1;
      checks++;
      if (cmd_ready !== 1'b1) begin errors++; $display("FAIL bcast_release_cmd_ready: got %0b, required 1", cmd_ready); end
      drain();
   endtask

   task automatic test_scan();
      issue(2'b10, 5'd30, 5'd3);
      drain();
      rand_ready = 1'b1;
      issue(2'b10, 5'(32'($urandom_range(0, 31))), 5'd9);
      issue(2'b10, 5'd5, 5'd31);
      drain();
      rand_ready = 1'b0;
      out_ready  = 1'b1;
   endtask

   task automatic test_num20();
      sel = 1'b1;
      issue(2'b00, 5'd25, 5'd0);
      checks += 2;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL n20_reject_valid: got %0b, required 0", out_valid); end
      if (err_pulse !== 1'b1) begin errors++; $display("FAIL n20_reject_err: got %0b, required 1", err_pulse); end
      @(posedge clk);
      #1;
      checks++;
      if (err_pulse !== 1'b0) begin errors++; $display("FAIL n20_err_width: got %0b, required 0", err_pulse); end
      issue(2'b10, 5'd18, 5'd2);
      drain();
      issue(2'b00, 5'd19, 5'd0);
      issue(2'b10, 5'd20, 5'd1);
      drain();
      sel = 1'b0;
   endtask

   task automatic test_back_to_back();
      int idle0;
      issue(2'b10, 5'd0, 5'd1);
      idle0 = idle_cycles;
      issue(2'b00, 5'd5, 5'd0);
      checks += 2;
      if (idle_cycles !== idle0) begin errors++; $display("FAIL b2b_idle: got %0d idle cycles, required 0", idle_cycles - idle0); end
      if (out_index !== 5'd5) begin errors++; $display("FAIL b2b_index: got %0d, required 5", out_index); end
      issue(2'b11, 5'd2, 5'd0);
      checks += 2;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL rsvd_valid: got %0b, required 0", out_valid); end
      if (err_pulse !== 1'b1) begin errors++; $display("FAIL rsvd_err: got %0b, required 1", err_pulse); end
      drain();
   endtask

   task automatic test_reset_mid_scan();
      bit hit = 1'b0;
      issue(2'b10, 5'd0, 5'd7);
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (out_valid && out_index == 5'd2) begin
            hit = 1'b1;
            break;
         end
      end
      checks++;
      if (!hit) begin errors++; $display("FAIL midscan_reach: got no beat with index 2, required one"); end
      #2 rst = 1'b1;
      #1;
      exp_q.delete();
      err_due = 1'b0;
      checks += 5;
      if (out_valid !== 1'b0)   begin errors++; $display("FAIL midrst_valid: got %0b, required 0", out_valid); end
      if (out_onehot !== 32'd0) begin errors++; $display("FAIL midrst_onehot: got %h, required 0", out_onehot); end
      if (out_index !== 5'd0)   begin errors++; $display("FAIL midrst_index: got %0d, required 0", out_index); end
      if (out_last !== 1'b0)    begin errors++; $display("FAIL midrst_last: got %0b, required 0", out_last); end
      if (cmd_ready !== 1'b1)   begin errors++; $display("FAIL midrst_cmd_ready: got %0b, required 1", cmd_ready); end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_resume: got out_valid=%0b, required 0", out_valid); end
      @(posedge clk);
      #1;
      issue(2'b00, 5'd7, 5'd0);
      checks++;
      if (out_onehot !== 32'h0000_0080) begin errors++; $display("FAIL post_rst_decode: got %h, required 00000080", out_onehot); end
      drain();
   endtask

   initial begin
      test_reset();
      test_decode();
      test_bcast_hold();
      test_scan();
      test_num20();
      test_back_to_back();
      test_reset_mid_scan();
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL leftover_beats: got %0d pending, required 0", exp_q.size()); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
